sram_controller: RTL and testbench

- Memory-stage responder for the pipeline's `mem_read`/`mem_write` commands.
- Translates one 32-bit word access into two 16-bit transactions on the external SRAM.
- Holds `ready` low while an access is in flight, so hazard/freeze logic can stall every pipeline stage.
- Returns assembled 32-bit read data to the MEM/WB path.

---
 rtl/sram_controller.sv | 158 +++++++++++++++
 tb/tb_sram_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module  : sram_controller
// Brief   : Splits one 32-bit load/store into two 16-bit SRAM half-accesses,
//           stalling the pipeline through ready until the word completes.
// Revision: 1.0
// ============================================================================
module sram_controller #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    localparam int              c_cnt_w    = $clog2(ACCESS_CYCLES) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 op_write_q, op_write_d;
    logic [16:0]          word_addr_q, word_addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          read_data_q, read_data_d;

    logic [31:0]          w_offset;
    logic                 w_cnt_last;
    logic                 w_dq_oe;
    logic [15:0]          w_dq_out;
    logic                 unused_offset_bits;

    assign w_offset           = address - BASE_ADDR;
    assign w_cnt_last         = (cnt_q == c_cnt_last);
    // Only offset[18:2] selects a word; the rest wraps away.
    assign unused_offset_bits = ^{w_offset[31:19], w_offset[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_write_q  <= 1'b0;
            word_addr_q <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_write_q  <= op_write_d;
            word_addr_q <= word_addr_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_write_d  = op_write_q;
        word_addr_d = word_addr_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        case (state_q)
            S_IDLE: begin
                if (mem_write || mem_read) begin
                    op_write_d  = mem_write;
                    word_addr_d = w_offset[18:2];
                    wdata_d     = write_data;
                    cnt_d       = '0;
                    state_d     = S_LOW;
                end
            end
            S_LOW: begin
                if (w_cnt_last) begin
                    if (!op_write_q) begin
                        read_data_d[15:0] = SRAM_DQ;
                    end
                    cnt_d   = '0;
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            S_HIGH: begin
                if (w_cnt_last) begin
                    if (!op_write_q) begin
                        read_data_d[31:16] = SRAM_DQ;
                    end
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs decode from registered state only, so reset idles them at once.
    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        w_dq_oe   = 1'b0;
        w_dq_out  = '0;
        case (state_q)
            S_LOW: begin
                SRAM_ADDR = {word_addr_q, 1'b0};
                SRAM_WE_N = ~op_write_q;
                w_dq_oe   = op_write_q;
                w_dq_out  = wdata_q[15:0];
            end
            S_HIGH: begin
                SRAM_ADDR = {word_addr_q, 1'b1};
                SRAM_WE_N = ~op_write_q;
                w_dq_oe   = op_write_q;
                w_dq_out  = wdata_q[31:16];
            end
            default: begin
                SRAM_ADDR = '0;
            end
        endcase
    end

    assign SRAM_DQ   = w_dq_oe ? w_dq_out : 16'bz;
    assign read_data = read_data_q;
    assign ready     = ~((mem_read | mem_write) && (state_q != S_DONE));

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_controller
// Brief   : Directed bench for sram_controller with a behavioural SRAM model.
// Revision: 1.0
// ============================================================================
module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_read;

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_UB_N  (SRAM_UB_N),
        .SRAM_LB_N  (SRAM_LB_N),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_OE_N  (SRAM_OE_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM: OE/CE tied active, so it drives whenever WE_N is high.
    logic [15:0] mem [0:262143];
    always @(posedge clk) begin
        if (SRAM_WE_N == 1'b0) mem[SRAM_ADDR] <= SRAM_DQ;
    end
    assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR] : 16'bz;

    task automatic start_req(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        mem_write  = wr;
        mem_read   = rd;
        address    = a;
        write_data = d;
    endtask

    task automatic idle_req();
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
    endtask

    // Entered at posedge+1 of cycle 0; returns at posedge+2 of the ready cycle.
    task automatic run_txn(output int lat, output int we_low,
                           output logic [17:0] addr_lo, output logic [17:0] addr_hi);
        lat = -1;
        we_low = 0;
        addr_lo = '0;
        addr_hi = '0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (c == 1) addr_lo = SRAM_ADDR;
            if (c == 3) addr_hi = SRAM_ADDR;
            if (SRAM_WE_N == 1'b0) we_low++;
            if (ready) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL reset_we_n got %b want 1", SRAM_WE_N); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data got %h want 00000000", read_data); end
        checks++; if (SRAM_ADDR !== 18'h0) begin errors++; $display("FAIL reset_addr got %h want 00000", SRAM_ADDR); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if ({SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N} !== 4'b0000)
            begin errors++; $display("FAIL reset_tied got %b want 0000", {SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        int lat, wl;
        logic [17:0] alo, ahi;
        start_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        run_txn(lat, wl, alo, ahi);
        checks++; if (lat !== 5) begin errors++; $display("FAIL store_latency got %0d want 5", lat); end
        checks++; if (wl !== 4) begin errors++; $display("FAIL store_we_cycles got %0d want 4", wl); end
        checks++; if (alo !== 18'h0 || ahi !== 18'h1) begin errors++; $display("FAIL store_addr got %h/%h want 00000/00001", alo, ahi); end
        idle_req();
        @(posedge clk);
        #1;
        checks++; if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD)
            begin errors++; $display("FAIL store_sram got %h/%h want beef/dead", mem[0], mem[1]); end
        start_req(1'b0, 1'b1, 32'd1024, 32'h0);
        run_txn(lat, wl, alo, ahi);
        checks++; if (lat !== 5) begin errors++; $display("FAIL load_latency got %0d want 5", lat); end
        checks++; if (wl !== 0) begin errors++; $display("FAIL load_we_cycles got %0d want 0", wl); end
        checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got %h want deadbeef", read_data); end
        last_read = 32'hDEADBEEF;
        idle_req();
        @(posedge clk);
        #1;
    endtask

    task automatic test_addr_translation();
        int lat, wl;
        logic [17:0] alo, ahi;
        start_req(1'b1, 1'b0, 32'd1036, 32'hCAFEF00D);
        run_txn(lat, wl, alo, ahi);
        idle_req();
        @(posedge clk);
        #1;
        start_req(1'b0, 1'b1, 32'd1036, 32'h0);
        run_txn(lat, wl, alo, ahi);
        checks++; if (alo !== 18'd6 || ahi !== 18'd7) begin errors++; $display("FAIL read1036_addr got %h/%h want 00006/00007", alo, ahi); end
        checks++; if (read_data !== 32'hCAFEF00D) begin errors++; $display("FAIL read1036_data got %h want cafef00d", read_data); end
        last_read = 32'hCAFEF00D;
        idle_req();
        @(posedge clk);
        #1;
        start_req(1'b1, 1'b0, 32'd1024 + 32'h7FFFC, 32'h13579BDF);
        run_txn(lat, wl, alo, ahi);
        checks++; if (alo !== 18'h3FFFE || ahi !== 18'h3FFFF) begin errors++; $display("FAIL top_addr got %h/%h want 3fffe/3ffff", alo, ahi); end
        idle_req();
        @(posedge clk);
        #1;
        checks++; if (mem[18'h3FFFE] !== 16'h9BDF || mem[18'h3FFFF] !== 16'h1357)
            begin errors++; $display("FAIL top_sram got %h/%h want 9bdf/1357", mem[18'h3FFFE], mem[18'h3FFFF]); end
    endtask

    task automatic test_idle();
        int bad_ready, bad_we, bad_rd, bad_dq;
        bad_ready = 0; bad_we = 0; bad_rd = 0; bad_dq = 0;
        idle_req();
        for (int i = 0; i < 10; i++) begin
            #1;
            if (ready !== 1'b1) bad_ready++;
            if (SRAM_WE_N !== 1'b1) bad_we++;
            if (read_data !== last_read) bad_rd++;
            if (SRAM_DQ !== mem[SRAM_ADDR]) bad_dq++;
            @(posedge clk);
            #1;
        end
        checks++; if (bad_ready !== 0) begin errors++; $display("FAIL idle_ready got %0d low cycles want 0", bad_ready); end
        checks++; if (bad_we !== 0) begin errors++; $display("FAIL idle_we_n got %0d low cycles want 0", bad_we); end
        checks++; if (bad_rd !== 0) begin errors++; $display("FAIL idle_read_data got %0d changed cycles want 0", bad_rd); end
        checks++; if (bad_dq !== 0) begin errors++; $display("FAIL idle_dq got %0d driven cycles want 0", bad_dq); end
    endtask

    task automatic test_both_requests();
        int lat, wl;
        logic [17:0] alo, ahi;
        start_req(1'b1, 1'b1, 32'd1028, 32'h12345678);
        run_txn(lat, wl, alo, ahi);
        checks++; if (wl !== 4) begin errors++; $display("FAIL both_we_cycles got %0d want 4", wl); end
        checks++; if (read_data !== last_read) begin errors++; $display("FAIL both_read_data got %h want %h", read_data, last_read); end
        idle_req();
        @(posedge clk);
        #1;
        checks++; if (mem[2] !== 16'h5678 || mem[3] !== 16'h1234)
            begin errors++; $display("FAIL both_sram got %h/%h want 5678/1234", mem[2], mem[3]); end
    endtask

    task automatic test_reset_mid_access();
        int lat, wl;
        logic [17:0] alo, ahi;
        start_req(1'b1, 1'b0, 32'd1032, 32'h0BADF00D);
        repeat (3) @(posedge clk);
        #3;
        checks++; if (SRAM_WE_N !== 1'b0) begin errors++; $display("FAIL pre_reset_we_n got %b want 0", SRAM_WE_N); end
        rst = 1'b0;
        #1;
        checks++; if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL midrst_we_n got %b want 1", SRAM_WE_N); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL midrst_read_data got %h want 00000000", read_data); end
        checks++; if (SRAM_ADDR !== 18'h0) begin errors++; $display("FAIL midrst_addr got %h want 00000", SRAM_ADDR); end
        idle_req();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        start_req(1'b0, 1'b1, 32'd1024, 32'h0);
        run_txn(lat, wl, alo, ahi);
        checks++; if (lat !== 5) begin errors++; $display("FAIL postrst_latency got %0d want 5", lat); end
        checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL postrst_data got %h want deadbeef", read_data); end
        last_read = 32'hDEADBEEF;
        idle_req();
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat, wl;
        logic [17:0] alo, ahi;
        start_req(1'b1, 1'b0, 32'd1040, 32'hA5A5A5A5);
        run_txn(lat, wl, alo, ahi);
        checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_write_latency got %0d want 5", lat); end
        start_req(1'b0, 1'b1, 32'd1040, 32'h0);
        @(posedge clk);
        #1;
        run_txn(lat, wl, alo, ahi);
        checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_read_latency got %0d want 5", lat); end
        checks++; if (alo !== 18'd8 || ahi !== 18'd9) begin errors++; $display("FAIL b2b_addr got %h/%h want 00008/00009", alo, ahi); end
        checks++; if (read_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_data got %h want a5a5a5a5", read_data); end
        idle_req();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        last_read = 32'h0;
        idle_req();
        test_reset();
        test_store_load();
        test_addr_translation();
        test_idle();
        test_both_requests();
        test_reset_mid_access();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
